// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch PC owner for the pipelined MIPS core. Picks the next PC
//            from PC+4, branch/jump targets, exception vector and EPC, and
//            buffers a redirect that arrives while the front end is stalled.
//            Optional macro PC_ADEL_CHECK_EN adds the fetch_adel output.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        redirect_pending
`ifdef PC_ADEL_CHECK_EN
    ,
    output logic        fetch_adel
`endif
);

    localparam logic c_RUN  = 1'b0;
    localparam logic c_PEND = 1'b1;

    logic        r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_target;
    logic        w_redirect;
    logic [31:0] w_redirect_target;

    // br_target wins when both redirects are (illegally) raised together.
    assign w_redirect        = br_taken | jr_en;
    assign w_redirect_target = br_taken ? br_target : jr_target;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_pend_target <= 32'h0;
            r_state       <= c_RUN;
        end else if (exc_req) begin
            r_pc    <= EXC_VECTOR;
            r_state <= c_RUN;
        end else if (eret_req) begin
            r_pc    <= epc;
            r_state <= c_RUN;
        end else if (stall) begin
            if (w_redirect) begin
                r_pend_target <= w_redirect_target;
                r_state       <= c_PEND;
            end
        end else if (r_state == c_PEND) begin
            // A fresh redirect on the release edge supersedes the buffered one.
            r_pc    <= w_redirect ? w_redirect_target : r_pend_target;
            r_state <= c_RUN;
        end else if (w_redirect) begin
            r_pc <= w_redirect_target;
        end else begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign pc               = r_pc;
    assign pc4              = r_pc + 32'd4;
    assign redirect_pending = (r_state == c_PEND);

`ifdef PC_ADEL_CHECK_EN
    assign fetch_adel = (r_pc[1:0] != 2'b00) || (r_pc < TEXT_LO) || (r_pc > TEXT_HI);
`else
    // Text bounds only matter for the address-error check.
    logic w_unused_text_bounds;
    assign w_unused_text_bounds = ^{TEXT_LO, TEXT_HI};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed and randomized bench for pc_sequencer against a
//            behavioural next-PC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] c_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] c_EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] c_TEXT_LO  = 32'h0000_3000;
    localparam logic [31:0] c_TEXT_HI  = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, jr_en, exc_req, eret_req;
    logic [31:0] br_target, jr_target, epc;
    logic [31:0] pc, pc4;
    logic        redirect_pending;
`ifdef PC_ADEL_CHECK_EN
    logic        fetch_adel;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_buf;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .jr_en            (jr_en),
        .jr_target        (jr_target),
        .exc_req          (exc_req),
        .eret_req         (eret_req),
        .epc              (epc),
        .pc               (pc),
        .pc4              (pc4),
        .redirect_pending (redirect_pending)
`ifdef PC_ADEL_CHECK_EN
        ,
        .fetch_adel       (fetch_adel)
`endif
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: any redirect (branch or jump) is one event; a stalled one is
    // remembered, and a held memory is spent on the first unstalled edge.
    task automatic model_step();
        if (reset) begin
            m_pc = c_RESET_PC; m_pend = 1'b0; m_buf = 32'h0;
        end else if (exc_req) begin
            m_pc = c_EXC_VEC; m_pend = 1'b0;
        end else if (eret_req) begin
            m_pc = epc; m_pend = 1'b0;
        end else if (stall) begin
            if (br_taken || jr_en) begin
                m_buf  = br_taken ? br_target : jr_target;
                m_pend = 1'b1;
            end
        end else if (br_taken || jr_en) begin
            m_pc = br_taken ? br_target : jr_target; m_pend = 1'b0;
        end else if (m_pend) begin
            m_pc = m_buf; m_pend = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check32({tag, ".pc"}, pc, m_pc);
        check32({tag, ".pc4"}, pc4, m_pc + 32'd4);
        check32({tag, ".pend"}, {31'b0, redirect_pending}, {31'b0, m_pend});
`ifdef PC_ADEL_CHECK_EN
        check32({tag, ".adel"}, {31'b0, fetch_adel},
                {31'b0, (m_pc[1:0] != 2'b00) || (m_pc < c_TEXT_LO) || (m_pc > c_TEXT_HI)});
`endif
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; br_taken = 1'b0; jr_en = 1'b0;
        exc_req = 1'b0; eret_req = 1'b0;
    endtask

    initial begin
        idle();
        br_target = '0; jr_target = '0; epc = '0;
        m_pc = '0; m_pend = 1'b0; m_buf = '0;

        // Reset sequencing
        reset = 1'b1;
        tick("rst0");
        tick("rst1");
        check32("rst_pc", pc, 32'h3000);
        reset = 1'b0;
        tick("seq1"); check32("seq1_abs", pc, 32'h3004);
        tick("seq2"); check32("seq2_abs", pc, 32'h3008);
        tick("seq3"); check32("seq3_abs", pc, 32'h300C);
        tick("seq4"); check32("seq4_abs", pc, 32'h3010);

        // Stall hold
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("hold"); check32("hold_abs", pc, 32'h3010);
        end
        stall = 1'b0;
        tick("unhold"); check32("unhold_abs", pc, 32'h3014);
        tick("adv"); tick("adv"); tick("adv");
        check32("at3020", pc, 32'h3020);

        // Branch under stall
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h3100;
        tick("brstall"); check32("brstall_pend", {31'b0, redirect_pending}, 32'd1);
        br_taken = 1'b0;
        tick("brhold"); tick("brhold");
        check32("brhold_pc", pc, 32'h3020);
        stall = 1'b0;
        tick("brrel"); check32("brrel_pc", pc, 32'h3100);
        check32("brrel_pend", {31'b0, redirect_pending}, 32'd0);

        // Exception beats buffered redirect
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h3200;
        tick("pend3200");
        br_taken = 1'b0; exc_req = 1'b1;
        tick("exc"); check32("exc_pc", pc, 32'h4180);
        exc_req = 1'b0; stall = 1'b0;
        tick("postexc"); check32("postexc_pc", pc, 32'h4184);

        // Eret and priority
        eret_req = 1'b1; epc = 32'h3044; br_taken = 1'b1; br_target = 32'h3300;
        tick("eret"); check32("eret_pc", pc, 32'h3044);
        br_taken = 1'b0; exc_req = 1'b1;
        tick("exceret"); check32("exceret_pc", pc, 32'h4180);
        idle();

        // Wrap-around and verbatim misaligned targets
        jr_en = 1'b1; jr_target = 32'hFFFF_FFFC;
        tick("top"); check32("top_pc4", pc4, 32'h0);
        jr_en = 1'b0;
        tick("wrap"); check32("wrap_pc", pc, 32'h0);
        jr_en = 1'b1; jr_target = 32'h3002;
        tick("mis"); check32("mis_pc", pc, 32'h3002);
`ifdef PC_ADEL_CHECK_EN
        check32("adel_3002", {31'b0, fetch_adel}, 32'd1);
`endif
        jr_target = 32'h7000;
        tick("j7000");
`ifdef PC_ADEL_CHECK_EN
        check32("adel_7000", {31'b0, fetch_adel}, 32'd1);
`endif
        jr_target = 32'h6FFC;
        tick("j6ffc");
`ifdef PC_ADEL_CHECK_EN
        check32("adel_6ffc", {31'b0, fetch_adel}, 32'd0);
`endif

        // Branch beats jump when both asserted
        br_taken = 1'b1; br_target = 32'h3500; jr_target = 32'h3600;
        tick("both"); check32("both_pc", pc, 32'h3500);
        idle();

        // Newer buffered redirect overwrites older
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h3400;
        tick("old");
        br_taken = 1'b0; jr_en = 1'b1; jr_target = 32'h3480;
        tick("new");
        idle();
        tick("newrel"); check32("newrel_pc", pc, 32'h3480);

        // Redirect on the release edge supersedes the buffer
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h3600;
        tick("buf3600");
        stall = 1'b0; br_taken = 1'b0; jr_en = 1'b1; jr_target = 32'h3700;
        tick("supersede"); check32("supersede_pc", pc, 32'h3700);
        idle();

        // Reset clears a buffered redirect
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h3800;
        tick("buf3800");
        idle(); reset = 1'b1;
        tick("rstbuf"); check32("rstbuf_pend", {31'b0, redirect_pending}, 32'd0);
        reset = 1'b0;
        tick("rstbuf2"); check32("rstbuf2_pc", pc, 32'h3004);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            exc_req   = ($urandom_range(0, 15) == 0);
            eret_req  = ($urandom_range(0, 15) == 0);
            stall     = ($urandom_range(0, 2) == 0);
            br_taken  = ($urandom_range(0, 3) == 0);
            jr_en     = ($urandom_range(0, 3) == 0);
            br_target = $urandom_range(0, 3) == 0 ? 32'($urandom) : 32'h3000 + {18'b0, 12'($urandom), 2'b00};
            jr_target = $urandom_range(0, 3) == 0 ? 32'($urandom) : 32'h5000 + {18'b0, 12'($urandom), 2'b00};
            epc       = 32'($urandom);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch program counter of the pipelined MIPS core and decides its next value every cycle.
- Chooses among sequential PC+4, branch target, jump-register target, exception vector and EPC (eret).
- Holds the PC when the pipeline stalls.
- A branch or jump resolved during a stall is buffered, then applied once the stall releases, so the delay slot still advances.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded by reset.
- EXC_VECTOR, 32'h0000_4180, exception/interrupt handler entry.
- TEXT_LO, 32'h0000_3000, lowest legal fetch address (used only by the optional feature).
- TEXT_HI, 32'h0000_6FFC, highest legal fetch address (used only by the optional feature).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit freezes F/D; PC must hold.
- br_taken  in  1  D-stage branch resolved taken.
- br_target  in  32  branch target address.
- jr_en  in  1  D-stage jump (j/jal/jr/jalr) redirect.
- jr_target  in  32  jump target address.
- exc_req  in  1  CP0 requests exception/interrupt entry.
- eret_req  in  1  eret committing.
- epc  in  32  return address from CP0.
- pc  out  32  current fetch address (registered).
- pc4  out  32  pc + 4, combinational from pc.
- redirect_pending  out  1  a buffered redirect is waiting (registered).

Behaviour:
- The clock and reset are fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - pc = RESET_PC
  - redirect_pending = 0
  - pending target register = 0
  - state = RUN
  - Reset wins over every other input and clears any buffered redirect.
- States: RUN (no buffered redirect) and PEND (redirect buffered). redirect_pending = 1 exactly in PEND.
- Next-PC priority each cycle, highest first:
  1. exc_req: pc <= EXC_VECTOR, state <= RUN. Applies even when stall = 1 and in PEND; the buffer is discarded.
  2. eret_req: pc <= epc, state <= RUN. Overrides stall; discards the buffer.
  3. stall = 1:
     - pc holds.
     - If br_taken or jr_en: buffer its target and go to PEND. A newer redirect overwrites an older buffered one.
  4. state = PEND and stall = 0:
     - If br_taken or jr_en: pc <= the new target, state <= RUN. The new redirect supersedes the buffer.
     - Otherwise: pc <= buffered target, state <= RUN.
  5. br_taken: pc <= br_target.
  6. jr_en: pc <= jr_target.
  7. Otherwise: pc <= pc + 4.
- br_taken and jr_en both high is illegal upstream. br_target wins, deterministically.
- Latency:
  - A redirect with stall = 0 takes effect on the next edge (1 cycle).
  - A redirect buffered under stall takes effect on the first edge with stall = 0.
- Arithmetic:
  - pc + 4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0 with no flag.
  - Targets are taken verbatim; the low 2 bits are not forced to 0.
- exc_req and eret_req asserted together: exc_req wins.

Optional Feature:
- Macro: PC_ADEL_CHECK_EN.
- When defined:
  - Extra output fetch_adel (out, 1), combinational.
  - fetch_adel = 1 when pc[1:0] != 0, pc < TEXT_LO, or pc > TEXT_HI.
  - Comparisons are unsigned.
  - Intended to feed CP0 as an AdEL exception. It has no effect on sequencing.
- When undefined:
  - The port does not exist.
  - No comparators are built.
  - Behaviour is otherwise identical.

Test Plan:
- Reset sequencing: assert reset 2 cycles, release, run 3 cycles.
  - pc = 3000 during reset, then 3004, 3008, 300C.
  - redirect_pending = 0 throughout.
- Stall hold: pc = 3010, stall high 3 cycles, then low.
  - pc stays 3010 for 3 edges, then 3014.
- Branch under stall: pc = 3020, stall = 1 with br_taken = 1 and br_target = 3100 for one cycle, stall kept 2 more cycles, then released.
  - pc holds 3020; redirect_pending = 1 from the next edge.
  - On the first unstalled edge pc = 3100 and redirect_pending = 0.
- Exception beats buffered redirect: in PEND with target 3200, assert exc_req with stall = 1.
  - Next edge pc = 4180, redirect_pending = 0.
  - The 3200 target is never fetched.
- Eret and priority: eret_req with epc = 3044 and br_taken with br_target = 3300 in the same cycle.
  - pc = 3044.
  - Then exc_req + eret_req together give pc = 4180.
- Optional feature (PC_ADEL_CHECK_EN): jr_target = 3002.
  - fetch_adel = 1 the cycle after the jump.
  - jr_target = 7000 gives fetch_adel = 1.
  - jr_target = 6FFC gives fetch_adel = 0.
